// File: rtl/dmem_resp.sv
// dmem_resp: single-outstanding word memory responder with programmable response latency.
//   clk        rising-edge clock for all state
//   rst_n      asynchronous active-low reset (array contents are not reset)
//   req_*      request channel; accepted on an edge with req_valid && req_ready
//   resp_*     response channel; held stable until resp_valid && resp_ready
//   txn_cnt    count of completed (handshaken) transactions, wraps at 16 bits
module dmem_resp #(
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_wr,
  output logic [31:0]       resp_rdata,
  output logic [15:0]       txn_cnt
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;
  localparam logic [3:0] WLOAD = LATENCY == 0 ? 4'd0 : 4'(LATENCY - 1);
  logic [1:0]        state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              resp_wr_q, resp_wr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [15:0]       txn_cnt_q, txn_cnt_d;
  logic              accept, commit, handshake, c_wen;
  logic [ADDR_W-1:0] c_addr;
  logic [31:0]       c_wdata;
  logic [31:0]       mem [2**ADDR_W];
  // With zero latency the commit happens on the accept edge itself, so the
  // commit fields come straight from the request port instead of the latches.
  always_comb begin
    accept    = rst_n && state_q == IDLE && req_valid;
    commit    = (accept && LATENCY == 0) || (state_q == WAIT && wcnt_q == 4'd0);
    handshake = state_q == RESP && resp_ready;
    c_addr    = state_q == IDLE ? req_addr : addr_q;
    c_wen     = state_q == IDLE ? req_wen : wen_q;
    c_wdata   = state_q == IDLE ? req_wdata : wdata_q;
    state_d   = accept ? (LATENCY == 0 ? RESP : WAIT) : commit ? RESP : handshake ? IDLE : state_q;
    wcnt_d    = accept ? WLOAD : (state_q == WAIT && wcnt_q != 4'd0) ? wcnt_q - 4'd1 : 4'd0;
    addr_d    = accept ? req_addr : addr_q;
    wen_d     = accept ? req_wen : wen_q;
    wdata_d   = accept ? req_wdata : wdata_q;
    resp_wr_d = commit ? c_wen : resp_wr_q;
    rdata_d   = commit ? (c_wen ? 32'h0 : mem[c_addr]) : rdata_q;
    txn_cnt_d = handshake ? txn_cnt_q + 16'd1 : txn_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wcnt_q    <= 4'd0;
      addr_q    <= '0;
      wen_q     <= 1'b0;
      wdata_q   <= 32'h0;
      resp_wr_q <= 1'b0;
      rdata_q   <= 32'h0;
      txn_cnt_q <= 16'h0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      addr_q    <= addr_d;
      wen_q     <= wen_d;
      wdata_q   <= wdata_d;
      resp_wr_q <= resp_wr_d;
      rdata_q   <= rdata_d;
      txn_cnt_q <= txn_cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (commit && c_wen) mem[c_addr] <= c_wdata;
  end
  assign req_ready  = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_wr    = resp_wr_q;
  assign resp_rdata = rdata_q;
  assign txn_cnt    = txn_cnt_q;
endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: directed vector bench for dmem_resp at LATENCY=2 and LATENCY=0.
module tb_dmem_resp;
  logic        clk, rst_n;
  logic        req_valid, req_ready, req_wen, resp_valid, resp_ready, resp_wr;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata, resp_rdata;
  logic [15:0] txn_cnt;
  logic        z_req_valid, z_req_ready, z_req_wen, z_resp_valid, z_resp_ready, z_resp_wr;
  logic [8:0]  z_req_addr;
  logic [31:0] z_req_wdata, z_resp_rdata;
  logic [15:0] z_txn_cnt;
  int          errors = 0;
  int          checks = 0;
  typedef struct {
    logic        wen;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [15:0] cnt;
  } vec_t;
  vec_t vt[8];
  dmem_resp #(.ADDR_W(9), .LATENCY(2)) d2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_wr(resp_wr),
    .resp_rdata(resp_rdata), .txn_cnt(txn_cnt)
  );
  dmem_resp #(.ADDR_W(9), .LATENCY(0)) d0 (
    .clk(clk), .rst_n(rst_n), .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_wen(z_req_wen), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .resp_valid(z_resp_valid), .resp_ready(z_resp_ready), .resp_wr(z_resp_wr),
    .resp_rdata(z_resp_rdata), .txn_cnt(z_txn_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Issues one request on the LATENCY=2 instance, scrambles the request fields
  // after the accept edge, and reports in which cycle resp_valid was seen.
  task automatic txn2(input logic wen, input logic [8:0] addr, input logic [31:0] wdata, output int lat);
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_wen = ~wen; req_addr = ~addr; req_wdata = ~wdata;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask
  initial begin
    int lat;
    vt[0] = '{1'b1, 9'h010, 32'hDEADBEEF, 32'h0,        16'd1};
    vt[1] = '{1'b0, 9'h010, 32'h0,        32'hDEADBEEF, 16'd2};
    vt[2] = '{1'b1, 9'h1FF, 32'hA5A5A5A5, 32'h0,        16'd3};
    vt[3] = '{1'b1, 9'h000, 32'h00000001, 32'h0,        16'd4};
    vt[4] = '{1'b0, 9'h1FF, 32'h0,        32'hA5A5A5A5, 16'd5};
    vt[5] = '{1'b0, 9'h000, 32'h0,        32'h00000001, 16'd6};
    vt[6] = '{1'b1, 9'h010, 32'hCAFEF00D, 32'h0,        16'd7};
    vt[7] = '{1'b0, 9'h010, 32'h0,        32'hCAFEF00D, 16'd8};
    rst_n = 1'b0;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    z_req_valid = 1'b0; z_req_wen = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_resp_ready = 1'b1;
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_wr", 32'(resp_wr), 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_cnt", 32'(txn_cnt), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      txn2(vt[i].wen, vt[i].addr, vt[i].wdata, lat);
      chk("vec_latency", 32'(lat), 32'd3);
      chk("vec_resp_wr", 32'(resp_wr), 32'(vt[i].wen));
      chk("vec_rdata", resp_rdata, vt[i].rdata);
      @(posedge clk);
      #1;
      chk("vec_resp_done", 32'(resp_valid), 32'd0);
      chk("vec_cnt", 32'(txn_cnt), 32'(vt[i].cnt));
    end
    resp_ready = 1'b0;
    txn2(1'b0, 9'h010, 32'h0, lat);
    chk("stall_latency", 32'(lat), 32'd3);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 9'h010; req_wdata = 32'h00000BAD;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", 32'(resp_valid), 32'd1);
      chk("stall_rdata", resp_rdata, 32'hCAFEF00D);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      chk("stall_cnt", 32'(txn_cnt), 32'd8);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_release_valid", 32'(resp_valid), 32'd0);
    chk("stall_release_cnt", 32'(txn_cnt), 32'd9);
    txn2(1'b0, 9'h010, 32'h0, lat);
    chk("ignored_req_rdata", resp_rdata, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    chk("ignored_req_cnt", 32'(txn_cnt), 32'd10);
    for (int e = 0; e < 8; e++) begin
      @(negedge clk);
      z_req_valid = 1'b1; z_req_wen = 1'b1;
      z_req_addr = (e % 2 == 0) ? 9'(20 + e) : 9'h1AA;
      z_req_wdata = (e % 2 == 0) ? 32'hA0000000 + 32'(e) : 32'hFFFFFFFF;
      @(posedge clk);
      #1;
      chk("lat0_wr_valid", 32'(z_resp_valid), 32'(e % 2 == 0));
      chk("lat0_wr_cnt", 32'(z_txn_cnt), 32'((e + 1) / 2));
    end
    for (int e = 0; e < 8; e++) begin
      @(negedge clk);
      z_req_valid = 1'b1;
      z_req_wen = (e % 2 == 0) ? 1'b0 : 1'b1;
      z_req_addr = (e % 2 == 0) ? 9'(26 - e) : 9'h1AA;
      z_req_wdata = 32'hFFFFFFFF;
      @(posedge clk);
      #1;
      chk("lat0_rd_valid", 32'(z_resp_valid), 32'(e % 2 == 0));
      chk("lat0_rd_cnt", 32'(z_txn_cnt), 32'(4 + (e + 1) / 2));
      if (e % 2 == 0) begin
        chk("lat0_rd_wr", 32'(z_resp_wr), 32'd0);
        chk("lat0_rd_rdata", z_resp_rdata, 32'hA0000000 + 32'(6 - e));
      end
    end
    @(negedge clk);
    z_req_valid = 1'b0;
    resp_ready = 1'b0;
    txn2(1'b1, 9'h020, 32'h00000055, lat);
    chk("resp_rst_latency", 32'(lat), 32'd3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("resp_rst_valid", 32'(resp_valid), 32'd0);
    chk("resp_rst_wr", 32'(resp_wr), 32'd0);
    chk("resp_rst_rdata", resp_rdata, 32'h0);
    chk("resp_rst_cnt", 32'(txn_cnt), 32'd0);
    chk("resp_rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 9'h020; req_wdata = 32'h00000BAD;
    @(posedge clk);
    #1;
    chk("in_rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b1;
    resp_ready = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("in_rst_no_accept", 32'(resp_valid), 32'd0);
    end
    txn2(1'b0, 9'h020, 32'h0, lat);
    chk("kept_write_rdata", resp_rdata, 32'h00000055);
    @(posedge clk);
    #1;
    chk("kept_write_cnt", 32'(txn_cnt), 32'd1);
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 9'h1FF; req_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("wait_rst_valid", 32'(resp_valid), 32'd0);
    chk("wait_rst_cnt", 32'(txn_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("wait_rst_aborted", 32'(resp_valid), 32'd0);
    end
    txn2(1'b0, 9'h1FF, 32'h0, lat);
    chk("aborted_write_rdata", resp_rdata, 32'hA5A5A5A5);
    @(posedge clk);
    #1;
    chk("aborted_write_cnt", 32'(txn_cnt), 32'd1);
    @(negedge clk);
    force d0.txn_cnt_q = 16'hFFFE;
    @(negedge clk);
    release d0.txn_cnt_q;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      z_req_valid = 1'b1; z_req_wen = 1'b0; z_req_addr = 9'(20);
      @(posedge clk);
      #1;
      z_req_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("wrap_valid", 32'(z_resp_valid), 32'd0);
      chk("wrap_cnt", 32'(z_txn_cnt), 32'(16'(16'hFFFF + i)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
